// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-requester arbiter.
//   ALU_W        default operand/result width
//   alu_op_t     3-bit ALU op code; bit 2 inverts b, bits [1:0] select the function
//   arb_state_t  arbiter transaction state
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [2:0] {
      AND  = 3'b000,
      OR   = 3'b001,
      ADD  = 3'b010,
      ANDN = 3'b100,
      ORN  = 3'b101,
      SUB  = 3'b110,
      SLT  = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: combinational N-bit ALU.
//   a, b       operands
//   f          op code (alu_op_t encoding); f[2] inverts b and injects carry-in
//   y          result
//   zero       y == 0
//   carry_out  carry out of the adder, arithmetic ops (f[1:0]==10) only
//   overflow   signed overflow of the adder, arithmetic ops only
// SLT returns 1 when a < b as signed values, using the sign of a - b
// corrected by signed overflow.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned N = ALU_W
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   f,
   output logic [N-1:0] y,
   output logic         zero,
   output logic         carry_out,
   output logic         overflow
);

   logic [N-1:0] bb;
   logic [N:0]   sum_w;
   logic         ovf_raw;

   always_comb begin
      bb      = f[2] ? ~b : b;
      sum_w   = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, f[2]};
      // Operands agree in sign but the sum does not.
      ovf_raw = (a[N-1] == bb[N-1]) && (sum_w[N-1] != a[N-1]);

      y         = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (f[1:0])
         2'b00: y = a & bb;
         2'b01: y = a | bb;
         2'b10: begin
            y         = sum_w[N-1:0];
            carry_out = sum_w[N];
            overflow  = ovf_raw;
         end
         default: y = {{(N-1){1'b0}}, sum_w[N-1] ^ ovf_raw};
      endcase
      zero = (y == '0);
   end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic.
//   req      request vector, bit i = requester i
//   pointer  0 favours requester 0, 1 favours requester 1 on contention
//   advance  grants are only issued while high
//   grant    one-hot (or zero) grant
// A lone requester is always granted; the pointer only breaks ties.
module rr_arb2
   import alu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pointer,
   input  logic       advance,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (advance) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters.
//   clk, reset             clock; synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (ready is the grant)
//   req_a, req_b           operands, requester i on [i*N +: N]
//   req_f                  op codes, requester i on [i*3 +: 3]
//   rsp_valid/rsp_ready    one-hot response handshake to the granted requester
//   rsp_y, rsp_zero,
//   rsp_carry_out,
//   rsp_overflow           registered ALU result and flags
// Flow: IDLE (grant + capture operands) -> EXEC (capture ALU outputs)
//       -> RESP (hold until the owner accepts) -> IDLE.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned N = ALU_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*N-1:0] req_a,
   input  logic [2*N-1:0] req_b,
   input  logic [5:0]     req_f,
   output logic [1:0]     rsp_valid,
   input  logic [1:0]     rsp_ready,
   output logic [N-1:0]   rsp_y,
   output logic           rsp_zero,
   output logic           rsp_carry_out,
   output logic           rsp_overflow
);

   arb_state_t   state_q, state_d;
   logic         ptr_q, ptr_d;
   logic         owner_q, owner_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [2:0]   f_q, f_d;
   logic [N-1:0] y_q, y_d;
   logic         zero_q, zero_d;
   logic         carry_q, carry_d;
   logic         ovf_q, ovf_d;

   logic [1:0]   grant;
   logic         arb_advance;
   logic [N-1:0] alu_y;
   logic         alu_zero;
   logic         alu_carry;
   logic         alu_ovf;

   // Gating with reset keeps req_ready low while reset is held and makes
   // reset win over a simultaneous request handshake.
   assign arb_advance = (state_q == IDLE) && !reset;

   rr_arb2 u_rr_arb2 (
      .req     (req_valid),
      .pointer (ptr_q),
      .advance (arb_advance),
      .grant   (grant)
   );

   alu #(.N(N)) u_alu (
      .a         (a_q),
      .b         (b_q),
      .f         (f_q),
      .y         (alu_y),
      .zero      (alu_zero),
      .carry_out (alu_carry),
      .overflow  (alu_ovf)
   );

   assign req_ready = grant;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      a_d       = a_q;
      b_d       = b_q;
      f_d       = f_q;
      y_d       = y_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      rsp_valid = '0;

      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               owner_d = grant[1];
               a_d     = grant[1] ? req_a[2*N-1:N] : req_a[N-1:0];
               b_d     = grant[1] ? req_b[2*N-1:N] : req_b[N-1:0];
               f_d     = grant[1] ? req_f[5:3]     : req_f[2:0];
               // Favour the requester that was not just served.
               ptr_d   = ~grant[1];
               state_d = EXEC;
            end
         end
         EXEC: begin
            y_d     = alu_y;
            zero_d  = alu_zero;
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         y_q     <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rsp_y         = y_q;
   assign rsp_zero      = zero_q;
   assign rsp_carry_out = carry_q;
   assign rsp_overflow  = ovf_q;

endmodule
